// File: rtl/sdq_pkg.sv
// Shared index arithmetic and occupancy helpers for the store-data queue.
package sdq_pkg;

    // Ring increment with an explicit wrap, so DEPTH need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
        return (idx == depth - 32'd1) ? 32'd0 : idx + 32'd1;
    endfunction

    // (base + off) mod depth, valid for base < depth and off <= depth.
    function automatic int unsigned idx_add_mod(input int unsigned base, input int unsigned off,
                                                input int unsigned depth);
        int unsigned sum;
        sum = base + off;
        return (sum >= depth) ? sum - depth : sum;
    endfunction

    function automatic logic cnt_is(input int unsigned cnt, input int unsigned val);
        return cnt == val;
    endfunction

endpackage

// File: rtl/sdq_ram.sv
// DEPTH x WIDTH storage, one synchronous write port and one combinational read port.
module sdq_ram #(
    parameter int unsigned DEPTH = 17,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sdq_queue.sv
// Store-data queue: in-order allocation, out-of-order data writes by index, in-order drain,
// with rollback truncation and flush. Storage lives in sdq_ram so it can become a macro.
module sdq_queue
    import sdq_pkg::*;
#(
    parameter int unsigned DEPTH = 17,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [IDX_W-1:0] deq_idx,
    output logic [WIDTH-1:0] deq_data,
    input  logic             rollback_en,
    input  logic [CNT_W-1:0] rollback_keep,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W-1:0] head_n;
    logic [IDX_W-1:0] tail_n;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] keep_k;
    logic [DEPTH-1:0] alloc_vec;
    logic [DEPTH-1:0] dvalid_vec;
    logic [DEPTH-1:0] alloc_n;
    logic [DEPTH-1:0] dvalid_n;
    logic [DEPTH-1:0] keep_mask;
    logic             wr_in_range;
    logic             wr_ok;
    logic             alloc_fire;
    logic             deq_fire;

    assign alloc_ready = ~cnt_is(32'(count), DEPTH);
    assign empty       = cnt_is(32'(count), 32'd0);
    assign full        = cnt_is(32'(count), DEPTH);
    assign alloc_idx   = tail;
    assign deq_idx     = head;

    assign deq_valid  = alloc_vec[head] & dvalid_vec[head] & ~rollback_en & ~flush;
    assign alloc_fire = alloc_valid & alloc_ready & ~rollback_en & ~flush;
    assign deq_fire   = deq_valid & deq_ready;

    assign keep_k      = (rollback_keep < count) ? rollback_keep : count;
    assign wr_in_range = 32'(wr_idx) < DEPTH;

    // An entry survives rollback when its ring distance from head is below keep_k.
    always_comb begin
        keep_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            keep_mask[i] = idx_add_mod(32'(i), DEPTH - 32'(head), DEPTH) < 32'(keep_k);
        end
    end

    // Writes land only on allocated entries, and in a rollback cycle only on survivors.
    assign wr_ok = wr_en & wr_in_range & alloc_vec[wr_idx] & ~flush
                 & (~rollback_en | keep_mask[wr_idx]);

    always_comb begin
        head_n   = head;
        tail_n   = tail;
        count_n  = count;
        alloc_n  = alloc_vec;
        dvalid_n = dvalid_vec;
        if (flush) begin
            head_n   = '0;
            tail_n   = '0;
            count_n  = '0;
            alloc_n  = '0;
            dvalid_n = '0;
        end else if (rollback_en) begin
            tail_n   = IDX_W'(idx_add_mod(32'(head), 32'(keep_k), DEPTH));
            count_n  = keep_k;
            alloc_n  = alloc_vec & keep_mask;
            dvalid_n = dvalid_vec & keep_mask;
            if (wr_ok) begin
                dvalid_n[wr_idx] = 1'b1;
            end
        end else begin
            if (wr_ok) begin
                dvalid_n[wr_idx] = 1'b1;
            end
            if (alloc_fire) begin
                alloc_n[tail]  = 1'b1;
                dvalid_n[tail] = 1'b0;
                tail_n         = IDX_W'(wrap_inc(32'(tail), DEPTH));
            end
            // Dequeue frees the head entry even if it is rewritten in the same cycle.
            if (deq_fire) begin
                alloc_n[head]  = 1'b0;
                dvalid_n[head] = 1'b0;
                head_n         = IDX_W'(wrap_inc(32'(head), DEPTH));
            end
            case ({alloc_fire, deq_fire})
                2'b10:   count_n = count + CNT_W'(1);
                2'b01:   count_n = count - CNT_W'(1);
                default: count_n = count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            alloc_vec  <= '0;
            dvalid_vec <= '0;
        end else begin
            head       <= head_n;
            tail       <= tail_n;
            count      <= count_n;
            alloc_vec  <= alloc_n;
            dvalid_vec <= dvalid_n;
        end
    end

    sdq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clock (clock),
        .we    (wr_ok),
        .waddr (wr_idx),
        .wdata (wr_data),
        .raddr (head),
        .rdata (deq_data)
    );

endmodule

// File: tb/tb_sdq_queue.sv
// Bench for sdq_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_sdq_queue;

    localparam int DEPTH = 17;
    localparam int WIDTH = 64;
    localparam int IDX_W = 5;
    localparam int CNT_W = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic             alloc_valid;
    logic             alloc_ready;
    logic [IDX_W-1:0] alloc_idx;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [IDX_W-1:0] deq_idx;
    logic [WIDTH-1:0] deq_data;
    logic             rollback_en;
    logic [CNT_W-1:0] rollback_keep;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    sdq_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .alloc_valid   (alloc_valid),
        .alloc_ready   (alloc_ready),
        .alloc_idx     (alloc_idx),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_data       (wr_data),
        .deq_valid     (deq_valid),
        .deq_ready     (deq_ready),
        .deq_idx       (deq_idx),
        .deq_data      (deq_data),
        .rollback_en   (rollback_en),
        .rollback_keep (rollback_keep),
        .flush         (flush),
        .count         (count),
        .empty         (empty),
        .full          (full)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of live entry indices starting at the head.
    int               mq[$];
    int               m_head;
    bit               m_dv[DEPTH];
    logic [WIDTH-1:0] m_data[DEPTH];

    function automatic bit in_q(input int idx);
        foreach (mq[i]) if (mq[i] == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_clear();
        mq.delete();
        m_head = 0;
        for (int i = 0; i < DEPTH; i++) m_dv[i] = 1'b0;
    endtask

    task automatic m_step();
        int k;
        int wi;
        int tl;
        bit dq;
        bit ap;
        wi = int'(wr_idx);
        if (flush) begin
            m_clear();
            return;
        end
        if (rollback_en) begin
            k = (int'(rollback_keep) < mq.size()) ? int'(rollback_keep) : mq.size();
            while (mq.size() > k) begin
                m_dv[mq[$]] = 1'b0;
                void'(mq.pop_back());
            end
            if (wr_en && in_q(wi)) begin
                m_dv[wi]   = 1'b1;
                m_data[wi] = wr_data;
            end
            return;
        end
        dq = (mq.size() > 0) && m_dv[mq[0]] && deq_ready;
        ap = alloc_valid && (mq.size() < DEPTH);
        tl = (m_head + mq.size()) % DEPTH;
        if (wr_en && in_q(wi)) begin
            m_dv[wi]   = 1'b1;
            m_data[wi] = wr_data;
        end
        if (dq) begin
            m_dv[mq[0]] = 1'b0;
            void'(mq.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (ap) begin
            m_dv[tl] = 1'b0;
            mq.push_back(tl);
        end
    endtask

    // Compare on the falling edge, then advance the model for the coming rising edge.
    always @(negedge clock) begin
        int e_tail;
        bit e_dv;
        if (reset) m_clear();
        e_tail = (m_head + mq.size()) % DEPTH;
        e_dv   = (mq.size() > 0) && m_dv[mq[0]] && !rollback_en && !flush;
        cmp("m_count", 64'(count), 64'(mq.size()));
        cmp("m_empty", 64'(empty), 64'(mq.size() == 0));
        cmp("m_full", 64'(full), 64'(mq.size() == DEPTH));
        cmp("m_alloc_ready", 64'(alloc_ready), 64'(mq.size() < DEPTH));
        cmp("m_alloc_idx", 64'(alloc_idx), 64'(e_tail));
        cmp("m_deq_idx", 64'(deq_idx), 64'(m_head));
        cmp("m_deq_valid", 64'(deq_valid), 64'(e_dv));
        if (e_dv) cmp("m_deq_data", deq_data, m_data[mq[0]]);
        if (!reset) m_step();
    end

    task automatic idle();
        alloc_valid   = 1'b0;
        wr_en         = 1'b0;
        wr_idx        = '0;
        wr_data       = '0;
        deq_ready     = 1'b0;
        rollback_en   = 1'b0;
        rollback_keep = '0;
        flush         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic do_alloc();
        alloc_valid = 1'b1;
        tick();
    endtask

    task automatic do_write(input int idx, input logic [63:0] d);
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(idx);
        wr_data = d;
        tick();
    endtask

    task automatic do_deq();
        deq_ready = 1'b1;
        tick();
    endtask

    initial begin
        int j;
        idle();
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        cmp("rst_count", 64'(count), 64'd0);
        cmp("rst_empty", 64'(empty), 64'd1);
        cmp("rst_alloc_ready", 64'(alloc_ready), 64'd1);

        // Asynchronous reset in the middle of traffic
        repeat (5) do_alloc();
        do_write(0, 64'h55);
        cmp("pre_rst_count", 64'(count), 64'd5);
        reset = 1'b1;
        #1;
        cmp("async_rst_count", 64'(count), 64'd0);
        cmp("async_rst_empty", 64'(empty), 64'd1);
        cmp("async_rst_alloc_idx", 64'(alloc_idx), 64'd0);
        cmp("async_rst_deq_valid", 64'(deq_valid), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Fill to full, write out of order, drain in order, wrap the tail
        for (int i = 0; i < DEPTH; i++) begin
            cmp("wrap_alloc_idx", 64'(alloc_idx), 64'(i));
            do_alloc();
        end
        cmp("wrap_full", 64'(full), 64'd1);
        cmp("wrap_alloc_ready", 64'(alloc_ready), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            j = (i * 5) % DEPTH;
            do_write(j, 64'(j * 32'h1111));
        end
        for (int i = 0; i < DEPTH; i++) begin
            cmp("drain_deq_valid", 64'(deq_valid), 64'd1);
            cmp("drain_deq_data", deq_data, 64'(i * 32'h1111));
            do_deq();
        end
        cmp("drain_empty", 64'(empty), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cmp("rewrap_alloc_idx", 64'(alloc_idx), 64'(i));
            do_alloc();
        end

        // Out-of-order data arrival holds the head
        do_write(2, 64'hA2);
        cmp("ooo_wait_idx0", 64'(deq_valid), 64'd0);
        do_write(0, 64'hA0);
        cmp("ooo_head0_valid", 64'(deq_valid), 64'd1);
        cmp("ooo_head0_data", deq_data, 64'hA0);
        do_deq();
        cmp("ooo_head1_idx", 64'(deq_idx), 64'd1);
        cmp("ooo_head1_stall", 64'(deq_valid), 64'd0);
        do_deq();
        cmp("ooo_stall_count", 64'(count), 64'd2);
        do_write(1, 64'hA1);
        cmp("ooo_head1_valid", 64'(deq_valid), 64'd1);
        cmp("ooo_head1_data", deq_data, 64'hA1);
        do_deq();
        cmp("ooo_head2_data", deq_data, 64'hA2);
        do_deq();
        cmp("ooo_empty", 64'(empty), 64'd1);
        cmp("ooo_deq_idx", 64'(deq_idx), 64'd3);

        // Full boundary: alloc blocked while a dequeue fires
        repeat (DEPTH) do_alloc();
        for (int i = 0; i < DEPTH; i++) do_write(i, 64'hF000 + 64'(i));
        cmp("full_count", 64'(count), 64'd17);
        cmp("full_flag", 64'(full), 64'd1);
        alloc_valid = 1'b1;
        deq_ready   = 1'b1;
        tick();
        cmp("full_deq_count", 64'(count), 64'd16);
        cmp("full_deq_alloc_ready", 64'(alloc_ready), 64'd1);
        cmp("full_deq_alloc_idx", 64'(alloc_idx), 64'd3);

        // Flush with ten live entries
        repeat (6) do_deq();
        cmp("pre_flush_count", 64'(count), 64'd10);
        flush = 1'b1;
        tick();
        cmp("flush_count", 64'(count), 64'd0);
        cmp("flush_alloc_idx", 64'(alloc_idx), 64'd0);
        cmp("flush_deq_idx", 64'(deq_idx), 64'd0);

        // Write to unallocated index 9 is dropped
        repeat (9) do_alloc();
        do_write(9, 64'hDEAD);
        do_alloc();
        for (int i = 0; i < 9; i++) do_write(i, 64'hB0 + 64'(i));
        repeat (9) do_deq();
        cmp("drop_head_idx", 64'(deq_idx), 64'd9);
        cmp("drop_head_valid", 64'(deq_valid), 64'd0);
        do_write(9, 64'hBEEF);
        cmp("drop_rewrite_data", deq_data, 64'hBEEF);
        do_deq();

        // Write to the entry being allocated in the same cycle is dropped
        alloc_valid = 1'b1;
        wr_en       = 1'b1;
        wr_idx      = IDX_W'(10);
        wr_data     = 64'hC0;
        tick();
        cmp("same_cycle_count", 64'(count), 64'd1);
        cmp("same_cycle_valid", 64'(deq_valid), 64'd0);
        do_write(10, 64'hC1);
        cmp("same_cycle_data", deq_data, 64'hC1);
        do_deq();

        // Rollback with head=14, count=6, keep 2
        repeat (3) do_alloc();
        for (int i = 11; i < 14; i++) do_write(i, 64'hD00 + 64'(i));
        repeat (3) do_deq();
        cmp("rb_head", 64'(deq_idx), 64'd14);
        repeat (6) do_alloc();
        do_write(14, 64'hE0E);
        do_write(16, 64'hE10);
        do_write(0, 64'hE00);
        do_write(1, 64'hE01);
        do_write(2, 64'hE02);
        cmp("rb_pre_count", 64'(count), 64'd6);
        rollback_en   = 1'b1;
        rollback_keep = CNT_W'(2);
        deq_ready     = 1'b1;
        wr_en         = 1'b1;
        wr_idx        = IDX_W'(0);
        wr_data       = 64'hBAD0;
        tick();
        cmp("rb_count", 64'(count), 64'd2);
        cmp("rb_tail", 64'(alloc_idx), 64'd16);
        cmp("rb_deq_suppressed", 64'(deq_idx), 64'd14);
        rollback_en   = 1'b1;
        rollback_keep = CNT_W'(5);
        wr_en         = 1'b1;
        wr_idx        = IDX_W'(15);
        wr_data       = 64'hE0F;
        tick();
        cmp("rb2_count", 64'(count), 64'd2);
        cmp("rb_head14_data", deq_data, 64'hE0E);
        do_deq();
        cmp("rb_head15_valid", 64'(deq_valid), 64'd1);
        cmp("rb_head15_data", deq_data, 64'hE0F);
        do_deq();
        cmp("rb_empty", 64'(empty), 64'd1);
        cmp("rb_alloc_idx", 64'(alloc_idx), 64'd16);
        do_alloc();
        cmp("rb_realloc_valid", 64'(deq_valid), 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdq_queue.md
Name: sdq_queue

Overview:
- Parametrised store-data queue. Entries are allocated in order at dispatch, written out of order by index when data arrives, and drained in order from the head at commit.
- Wraps a 1R1W storage array, which can be swapped for a memory macro, with allocation, per-entry data-valid tracking, rollback and flush.
- Sits between LSU dispatch/store-data writeback and the store commit path.

Parameters:
- DEPTH, 17, number of entries; need not be a power of two (2..64).
- WIDTH, 64, data bits per entry.
- IDX_W, $clog2(DEPTH), entry index width (derived).
- CNT_W, $clog2(DEPTH+1), occupancy width (derived).

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all control state.
- alloc_valid  in  1  request allocation of one entry at tail.
- alloc_ready  out  1  high when count < DEPTH.
- alloc_idx  out  IDX_W  index allocated when alloc fires (current tail).
- wr_en  in  1  write store data into an allocated entry.
- wr_idx  in  IDX_W  entry to write.
- wr_data  in  WIDTH  store data.
- deq_valid  out  1  head entry allocated and data-valid.
- deq_ready  in  1  consumer accepts head.
- deq_idx  out  IDX_W  current head index.
- deq_data  out  WIDTH  data of head entry (combinational read of array).
- rollback_en  in  1  truncate queue to first rollback_keep entries from head.
- rollback_keep  in  CNT_W  entries to retain.
- flush  in  1  synchronous clear of all entries.
- count  out  CNT_W  registered occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- State: head, tail (IDX_W), count (CNT_W), alloc_vec[DEPTH], dvalid_vec[DEPTH]. The storage array is not reset.
- Reset (async) and flush (sync) both set: head=tail=0, count=0, all alloc/dvalid bits 0. Outputs after reset: alloc_ready=1, alloc_idx=0, deq_valid=0, deq_idx=0, count=0, empty=1, full=0. deq_data is undefined.
- Pointer increment wraps explicitly: DEPTH-1 -> 0. No power-of-two masking is permitted.
- Alloc fire = alloc_valid & alloc_ready. Effects: set alloc_vec[tail], clear dvalid_vec[tail], tail+1.
  - alloc_ready derives only from registered count, so no same-cycle reuse of a freed entry.
- Write: wr_en with alloc_vec[wr_idx]=1 writes the array and sets dvalid_vec[wr_idx] next cycle.
  - A write to an unallocated index is dropped entirely: no array write, no flag change.
  - A write to the entry being allocated in the same cycle is dropped, because it is not yet allocated.
  - A repeated write to a data-valid entry overwrites it.
- Dequeue: deq_valid = alloc_vec[head] & dvalid_vec[head] & ~rollback_en & ~flush.
  - Fire = deq_valid & deq_ready. Effects: clear both bits at head, head+1. Latency zero: data is presented in the same cycle deq_valid rises.
  - A write to head becomes visible on deq_valid the following cycle. There is no bypass.
- Count: +1 on alloc fire, -1 on deq fire. Simultaneous alloc and deq leaves it unchanged.
- Rollback: k = min(rollback_keep, count).
  - tail <= (head + k) mod DEPTH; count <= k.
  - Entries beyond the first k from head have alloc and dvalid cleared.
  - Rollback suppresses both alloc fire and deq fire that cycle. alloc_ready is still driven from count.
- Priority: reset > flush > rollback > (alloc, write, deq).
  - A write in a rollback cycle applies only if its index survives the truncation.
- Full case: with count==DEPTH, head==tail; alloc_ready=0. Empty case: deq_valid=0.

Decomposition:
- Package sdq_pkg: wrap-increment function and the index-add-mod-DEPTH function (taking DEPTH as an argument), plus a count-to-flag helper.
- Sub-module sdq_ram (DEPTH x WIDTH, 1R1W, combinational read, synchronous write, single clock).
  - Keeps the array replaceable by a hard macro; the control logic stays in sdq_queue.

Test Plan (DEPTH=17, WIDTH=64):
- Reset mid-traffic: reset asserted with count=5 -> count=0, empty=1, alloc_idx=0, deq_valid=0 immediately (async).
- Wrap: 17 allocs, write data=idx*0x1111 out of order, drain all, 3 more allocs -> full=1 after 17, alloc_idx sequence 0..16 then 0,1,2, deq_data in order 0x0..0x10*0x1111.
- Out-of-order data: alloc 0,1,2; write idx2 then idx0 -> deq_valid rises only after idx0 write (next cycle), stalls at head=1 until idx1 is written.
- Full boundary: count=17 with alloc_valid=1 and deq fire in the same cycle -> no alloc, count=16, alloc_ready=1 the next cycle.
- Rollback: count=6, head=14, rollback_keep=2 -> tail=16, count=2, entries 16,0,1,2 deallocated. A same-cycle deq is suppressed. A write to idx 0 in that cycle is dropped, while a write to idx 15 lands.
- Drops and flush:
  - Write to an unallocated idx 9 -> no dvalid change.
  - Flush with count=10 -> count=0 next cycle, alloc_idx=0.
